// File: rtl/hazard_sequencer_pkg.sv
// Shared types for the pipeline hazard sequencer: control bundle, FSM states,
// canonical output patterns and the memory-timeout default.
package my_pkg;

   typedef struct packed {
      logic PC_en;
      logic IF_ID_en;
      logic IF_ID_flush;
      logic Ctrl_Mux_DE;
      logic Pipe_en;
   } HAZARD_ctrl_o;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FLUSH,
      MEM_WAIT
   } hz_state_e;

   localparam int unsigned MEM_TIMEOUT_DEFAULT = 255;

   localparam HAZARD_ctrl_o HZ_IDLE   = HAZARD_ctrl_o'(5'b00010);
   localparam HAZARD_ctrl_o HZ_RUN    = HAZARD_ctrl_o'(5'b11001);
   localparam HAZARD_ctrl_o HZ_STALL  = HAZARD_ctrl_o'(5'b00011);
   localparam HAZARD_ctrl_o HZ_FLUSH  = HAZARD_ctrl_o'(5'b11111);
   localparam HAZARD_ctrl_o HZ_FREEZE = HAZARD_ctrl_o'(5'b00000);

endpackage

// File: rtl/hazard_sequencer_detect.sv
// Combinational load-use comparator between the EX-stage load and the
// decode-stage source registers; x0 never matches.
module hazard_detect (
   input  logic       ex_memread,
   input  logic [4:0] ex_rd,
   input  logic [4:0] id_rs1,
   input  logic [4:0] id_rs2,
   input  logic       id_uses_rs2,
   output logic       load_use
);

   always_comb begin
      load_use = ex_memread && (ex_rd != 5'd0) &&
                 ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));
   end

endmodule

// File: rtl/hazard_sequencer.sv
// Pipeline sequencer: start-up, load-use stalls, branch flushes and
// data-memory freeze with timeout, plus saturating stall/flush counters.
module hazard_sequencer
   import my_pkg::*;
#(
   parameter int unsigned FLUSH_CYCLES = 1,
   parameter int unsigned MEM_TIMEOUT  = MEM_TIMEOUT_DEFAULT,
   parameter int unsigned CNT_W        = 32
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             EN,
   input  logic             START,
   input  logic [4:0]       ID_Rs1,
   input  logic [4:0]       ID_Rs2,
   input  logic             ID_uses_rs2,
   input  logic             EX_MemRead,
   input  logic [4:0]       EX_Rd,
   input  logic             EX_branch_taken,
   input  logic             MEM_busy,
   output HAZARD_ctrl_o     HAZARD_o,
   output logic             busy,
   output logic             err,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);
   localparam logic [2:0] REM_INIT = 3'(FLUSH_CYCLES - 1);

   hz_state_e         state_q, state_d, ret_q, ret_d, eff_state;
   logic [2:0]        rem_q, rem_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic              err_q, err_d;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
   logic              load_use;
   HAZARD_ctrl_o      hz_ctrl;

   hazard_detect u_detect (
      .ex_memread  (EX_MemRead),
      .ex_rd       (EX_Rd),
      .id_rs1      (ID_Rs1),
      .id_rs2      (ID_Rs2),
      .id_uses_rs2 (ID_uses_rs2),
      .load_use    (load_use)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= IDLE;
         ret_q       <= RUN;
         rem_q       <= '0;
         wait_q      <= '0;
         err_q       <= 1'b0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         ret_q       <= ret_d;
         rem_q       <= rem_d;
         wait_q      <= wait_d;
         err_q       <= err_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   // Once memory is ready, MEM_WAIT behaves exactly as the state it froze.
   always_comb begin
      eff_state = state_q;
      if (state_q == MEM_WAIT && !MEM_busy) eff_state = ret_q;
   end

   always_comb begin
      state_d     = state_q;
      ret_d       = ret_q;
      rem_d       = rem_q;
      wait_d      = wait_q;
      err_d       = err_q;
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (EN) begin
         case (eff_state)
            IDLE: begin
               if (START && !err_q) state_d = RUN;
            end
            RUN: begin
               if (MEM_busy) begin
                  state_d = MEM_WAIT;
                  ret_d   = RUN;
                  wait_d  = WAIT_W'(1);
               end else if (EX_branch_taken) begin
                  wait_d = '0;
                  if (flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CNT_W'(1);
                  if (FLUSH_CYCLES > 1) begin
                     state_d = FLUSH;
                     rem_d   = REM_INIT;
                  end else begin
                     state_d = RUN;
                  end
               end else begin
                  state_d = RUN;
                  wait_d  = '0;
               end
            end
            FLUSH: begin
               if (MEM_busy) begin
                  state_d = MEM_WAIT;
                  ret_d   = FLUSH;
                  wait_d  = WAIT_W'(1);
               end else begin
                  wait_d  = '0;
                  rem_d   = rem_q - 3'd1;
                  state_d = (rem_q == 3'd1) ? RUN : FLUSH;
               end
            end
            default: begin
               if (wait_q == WAIT_MAX) begin
                  err_d   = 1'b1;
                  state_d = IDLE;
                  wait_d  = '0;
               end else begin
                  wait_d = wait_q + WAIT_W'(1);
               end
            end
         endcase
         if (state_q != IDLE && !hz_ctrl.PC_en && stall_cnt_q != '1)
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
         if (state_q != IDLE && !START) begin
            state_d = IDLE;
            wait_d  = '0;
         end
      end
   end

   always_comb begin
      hz_ctrl = HZ_IDLE;
      if (EN) begin
         case (eff_state)
            RUN: begin
               if (MEM_busy)             hz_ctrl = HZ_FREEZE;
               else if (EX_branch_taken) hz_ctrl = HZ_FLUSH;
               else if (load_use)        hz_ctrl = HZ_STALL;
               else                      hz_ctrl = HZ_RUN;
            end
            FLUSH:    hz_ctrl = MEM_busy ? HZ_FREEZE : HZ_FLUSH;
            MEM_WAIT: hz_ctrl = HZ_FREEZE;
            default:  hz_ctrl = HZ_IDLE;
         endcase
      end
   end

   assign HAZARD_o  = hz_ctrl;
   assign busy      = (state_q != IDLE);
   assign err       = err_q;
   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed bench for hazard_sequencer: the driver queues per-cycle expected
// outputs, a negedge monitor pops and compares them.
module tb_hazard_sequencer;
   import my_pkg::*;

   typedef struct packed {
      logic [4:0]  hz;
      logic        busy;
      logic        err;
      logic [31:0] stall;
      logic [31:0] flush;
   } exp_t;

   localparam logic [4:0] O_IDLE  = 5'b00010;
   localparam logic [4:0] O_RUN   = 5'b11001;
   localparam logic [4:0] O_STALL = 5'b00011;
   localparam logic [4:0] O_FLUSH = 5'b11111;
   localparam logic [4:0] O_FRZ   = 5'b00000;

   logic        clk = 1'b0;
   logic        rst, en, start, uses2, memrd, br, mbusy;
   logic [4:0]  rs1, rs2, exrd;
   HAZARD_ctrl_o hz;
   logic        busy, err;
   logic [31:0] stall_cnt, flush_cnt;

   exp_t  exp_q[$];
   string name_q[$];
   int    tests_run = 0;
   int    tests_failed = 0;
   exp_t  m_e, m_a;
   string m_n;

   always #5 clk = ~clk;

   hazard_sequencer #(
      .FLUSH_CYCLES (2),
      .MEM_TIMEOUT  (255),
      .CNT_W        (32)
   ) dut (
      .CLK             (clk),
      .RST             (rst),
      .EN              (en),
      .START           (start),
      .ID_Rs1          (rs1),
      .ID_Rs2          (rs2),
      .ID_uses_rs2     (uses2),
      .EX_MemRead      (memrd),
      .EX_Rd           (exrd),
      .EX_branch_taken (br),
      .MEM_busy        (mbusy),
      .HAZARD_o        (hz),
      .busy            (busy),
      .err             (err),
      .stall_cnt       (stall_cnt),
      .flush_cnt       (flush_cnt)
   );

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         m_e = exp_q.pop_front();
         m_n = name_q.pop_front();
         m_a = '{hz: hz, busy: busy, err: err, stall: stall_cnt, flush: flush_cnt};
         tests_run++;
         if (m_a !== m_e) begin
            tests_failed++;
            $display("FAIL %s: got hz=%b busy=%b err=%b stall=%0d flush=%0d, expected hz=%b busy=%b err=%b stall=%0d flush=%0d",
                     m_n, m_a.hz, m_a.busy, m_a.err, m_a.stall, m_a.flush,
                     m_e.hz, m_e.busy, m_e.err, m_e.stall, m_e.flush);
         end
      end
   end

   task automatic drv(input logic r, input logic e, input logic s, input logic mr,
                      input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2,
                      input logic u2, input logic b, input logic mb);
      rst = r; en = e; start = s; memrd = mr; exrd = rd;
      rs1 = r1; rs2 = r2; uses2 = u2; br = b; mbusy = mb;
   endtask

   task automatic base();
      drv(1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic chk(input string nm, input logic [4:0] h, input logic b,
                      input logic e, input int unsigned st, input int unsigned fl);
      exp_q.push_back('{hz: h, busy: b, err: e, stall: st, flush: fl});
      name_q.push_back(nm);
      @(posedge clk); #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      drv(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      @(posedge clk); #1;
      chk("reset", O_IDLE, 0, 0, 0, 0);

      base(); chk("idle_start", O_IDLE, 0, 0, 0, 0);
      chk("run", O_RUN, 1, 0, 0, 0);
      drv(0, 1, 1, 1, 5'd5, 5'd5, 5'd2, 0, 0, 0); chk("lu_rs1", O_STALL, 1, 0, 0, 0);
      base(); chk("lu_clear", O_RUN, 1, 0, 1, 0);
      drv(0, 1, 1, 1, 5'd0, 5'd0, 5'd0, 1, 0, 0); chk("rd0_nostall", O_RUN, 1, 0, 1, 0);
      drv(0, 1, 1, 1, 5'd7, 5'd1, 5'd7, 0, 0, 0); chk("rs2_unused", O_RUN, 1, 0, 1, 0);
      drv(0, 1, 1, 1, 5'd7, 5'd1, 5'd7, 1, 0, 0); chk("lu_rs2", O_STALL, 1, 0, 1, 0);
      base(); chk("run2", O_RUN, 1, 0, 2, 0);

      drv(0, 1, 1, 1, 5'd5, 5'd5, 5'd2, 0, 1, 0); chk("br_lu", O_FLUSH, 1, 0, 2, 0);
      base(); chk("flush2", O_FLUSH, 1, 0, 2, 1);
      base(); chk("flush_end", O_RUN, 1, 0, 2, 1);

      drv(0, 1, 1, 0, 5'd0, 5'd1, 5'd2, 0, 1, 0); chk("br2", O_FLUSH, 1, 0, 2, 1);
      for (int i = 0; i < 3; i++) begin
         drv(0, 0, 1, 0, 5'd0, 5'd1, 5'd2, 0, 0, 0); chk("en_low", O_IDLE, 1, 0, 2, 2);
      end
      base(); chk("flush_resume", O_FLUSH, 1, 0, 2, 2);
      base(); chk("run3", O_RUN, 1, 0, 2, 2);

      for (int i = 0; i < 10; i++) begin
         drv(0, 1, 1, 0, 5'd0, 5'd1, 5'd2, 0, 0, 1); chk("mem_busy", O_FRZ, 1, 0, 2 + i, 2);
      end
      base(); chk("mem_release", O_RUN, 1, 0, 12, 2);

      drv(0, 1, 1, 0, 5'd0, 5'd1, 5'd2, 0, 1, 1); chk("br_busy", O_FRZ, 1, 0, 12, 2);
      drv(0, 1, 1, 0, 5'd0, 5'd1, 5'd2, 0, 1, 0); chk("br_reeval", O_FLUSH, 1, 0, 13, 2);
      base(); chk("flush3", O_FLUSH, 1, 0, 13, 3);
      base(); chk("run4", O_RUN, 1, 0, 13, 3);

      drv(0, 1, 1, 0, 5'd0, 5'd1, 5'd2, 0, 1, 0); chk("br4", O_FLUSH, 1, 0, 13, 3);
      drv(0, 1, 1, 0, 5'd0, 5'd1, 5'd2, 0, 0, 1); chk("flush_busy", O_FRZ, 1, 0, 13, 4);
      base(); chk("flush_ret", O_FLUSH, 1, 0, 14, 4);
      base(); chk("run5", O_RUN, 1, 0, 14, 4);

      drv(0, 1, 0, 0, 5'd0, 5'd1, 5'd2, 0, 0, 0); chk("start_low", O_RUN, 1, 0, 14, 4);
      drv(0, 1, 0, 0, 5'd0, 5'd1, 5'd2, 0, 0, 0); chk("idle_back", O_IDLE, 0, 0, 14, 4);
      base(); chk("restart", O_IDLE, 0, 0, 14, 4);
      base(); chk("run6", O_RUN, 1, 0, 14, 4);

      drv(0, 1, 1, 0, 5'd0, 5'd1, 5'd2, 0, 0, 1); chk("wait_a", O_FRZ, 1, 0, 14, 4);
      chk("wait_b", O_FRZ, 1, 0, 15, 4);
      drv(1, 1, 1, 0, 5'd0, 5'd1, 5'd2, 0, 0, 1); chk("rst_cycle", O_FRZ, 1, 0, 16, 4);
      base(); chk("rst_midwait", O_IDLE, 0, 0, 0, 0);
      base(); chk("run7", O_RUN, 1, 0, 0, 0);

      for (int j = 0; j < 255; j++) begin
         drv(0, 1, 1, 0, 5'd0, 5'd1, 5'd2, 0, 0, 1); chk("busy255", O_FRZ, 1, 0, j, 0);
      end
      base(); chk("no_timeout", O_RUN, 1, 0, 255, 0);

      for (int j = 0; j < 256; j++) begin
         drv(0, 1, 1, 0, 5'd0, 5'd1, 5'd2, 0, 0, 1); chk("busy256", O_FRZ, 1, 0, 255 + j, 0);
      end
      for (int i = 0; i < 3; i++) begin
         base(); chk("err_idle", O_IDLE, 0, 1, 511, 0);
      end
      drv(1, 1, 1, 0, 5'd0, 5'd1, 5'd2, 0, 0, 0); chk("rst_err", O_IDLE, 0, 1, 511, 0);
      base(); chk("err_cleared", O_IDLE, 0, 0, 0, 0);
      base(); chk("run8", O_RUN, 1, 0, 0, 0);

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
      if (exp_q.size() > 0) begin
         tests_run++;
         tests_failed++;
         $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/hazard_sequencer.md
# hazard_sequencer

Pipeline sequencer for the 5-stage core. Owns the stage enables, the IF/ID flush and the ID-stage bubble select (`Ctrl_Mux_DE`, consumed by the decode stage as its control-zeroing mux) as one `HAZARD_ctrl_o` bundle. It sequences start-up, resolves load-use hazards against the decode-stage source registers, flushes on taken branches and freezes the pipe on data-memory wait, with timeout and performance counters.

## Interface
- `FLUSH_CYCLES`, 1: cycles IF/ID is flushed per taken branch, range 1..4.
- `MEM_TIMEOUT`, 255: max consecutive `MEM_busy` cycles before error.
- `CNT_W`, 32: width of the performance counters.

Ports:
- `CLK`  in  1  clock; everything on rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `EN`  in  1  global enable; low freezes state and counters.
- `START`  in  1  run request; low returns to IDLE.
- `ID_Rs1`, `ID_Rs2`  in  5 each  decode-stage source registers.
- `ID_uses_rs2`  in  1  decode instruction reads rs2.
- `EX_MemRead`  in  1  EX-stage instruction is a load.
- `EX_Rd`  in  5  EX-stage destination.
- `EX_branch_taken`  in  1  branch/jump resolved taken in EX.
- `MEM_busy`  in  1  data memory not ready.
- `HAZARD_o`  out  `HAZARD_ctrl_o`  {`PC_en`, `IF_ID_en`, `IF_ID_flush`, `Ctrl_Mux_DE`, `Pipe_en`}.
- `busy`  out  1  state ≠ IDLE.
- `err`  out  1  sticky memory-timeout flag.
- `stall_cnt`  out  `CNT_W`  cycles with `PC_en` = 0 while running.
- `flush_cnt`  out  `CNT_W`  taken-branch events.

## Operation
- States: IDLE, RUN, FLUSH, MEM_WAIT.
- IDLE:
  - Outputs are `PC_en` = `IF_ID_en` = `Pipe_en` = 0, `Ctrl_Mux_DE` = 1, `IF_ID_flush` = 0.
  - `START & EN & !err` → RUN.
- RUN, normal: all enables 1, `Ctrl_Mux_DE` = 0, flush 0.
- Mealy conditions in RUN, highest priority first:
  1. `MEM_busy`: `PC_en` = `IF_ID_en` = `Pipe_en` = 0, `Ctrl_Mux_DE` = 0 (full freeze); next state MEM_WAIT.
  2. `EX_branch_taken`: `PC_en` = 1, `IF_ID_flush` = 1, `Ctrl_Mux_DE` = 1, `Pipe_en` = 1.
     - `flush_cnt`++.
     - If `FLUSH_CYCLES` > 1 → FLUSH with remaining = `FLUSH_CYCLES` − 1.
  3. Load-use, defined as `EX_MemRead & EX_Rd != 0 & (EX_Rd == ID_Rs1 | (ID_uses_rs2 & EX_Rd == ID_Rs2))`:
     - `PC_en` = `IF_ID_en` = 0, `Ctrl_Mux_DE` = 1, `Pipe_en` = 1.
     - Stay in RUN. The hazard clears naturally next cycle.
- FLUSH: outputs as branch flush; decrement the remaining count; at 0 → RUN. `MEM_busy` in FLUSH freezes, holds the count and → MEM_WAIT with return state FLUSH.
- MEM_WAIT:
  - Full freeze while `MEM_busy`; the wait counter increments.
  - `MEM_busy` low: outputs follow the return state's Mealy rules that same cycle, and the next state is the return state.
  - Wait counter reaching `MEM_TIMEOUT` sets `err` → IDLE.
- `START` low in any non-IDLE state → IDLE next cycle. The outputs in that cycle are still those of the current state.
- `EN` low: state, counters and remaining count hold. All enables are forced to 0, flush 0, `Ctrl_Mux_DE` 1.
- `stall_cnt` increments on every EN-high, non-IDLE cycle with `PC_en` = 0. Both counters saturate at all-ones.
- `err` clears only on `RST`.

## Timing
- Reset values: state IDLE, `HAZARD_o` = {0,0,0,1,0}, `busy` 0, `err` 0, counters 0, wait/remaining counts 0.
- `RST` overrides all inputs, including mid-FLUSH or mid-MEM_WAIT.
- Hazard, branch and freeze outputs have zero-cycle latency (combinational from inputs and state). State and counters update at the edge.
- IDLE → first RUN cycle: 1 cycle after `START` sampled high.
- Branch + load-use in the same cycle: flush only; no extra stall is counted.
- Branch + `MEM_busy` in the same cycle: freeze only. The branch stays in EX and is re-evaluated after the wait.
- `EX_Rd` = 0 never stalls.

## Structure
- `my_pkg` holds:
  - `HAZARD_ctrl_o` packed struct, extended with `PC_en`, `IF_ID_en`, `IF_ID_flush`, `Pipe_en` beside the existing `Ctrl_Mux_DE`.
  - `hz_state_e` enum.
  - Timeout default constant.
- Sub-module `hazard_detect`: purely combinational load-use comparator, reusable for future forwarding checks. FSM and counters stay in the top.

## Test plan
- Reset, then `START` = 1: IDLE outputs {0,0,0,1,0} for 1 cycle, then RUN outputs {1,1,0,0,1}, `busy` = 1.
- `EX_MemRead` = 1, `EX_Rd` = 5, `ID_Rs1` = 5 for one cycle → `PC_en` = `IF_ID_en` = 0, `Ctrl_Mux_DE` = 1 that cycle, `stall_cnt` = 1. With `EX_Rd` = 0 → no stall.
- `EX_branch_taken` pulse with `FLUSH_CYCLES` = 2 → `IF_ID_flush` = 1 for exactly 2 cycles, `flush_cnt` = 1; simultaneous load-use → still `flush_cnt` = 1, `stall_cnt` unchanged.
- `MEM_busy` high 10 cycles → all enables 0 for 10 cycles, `stall_cnt` += 10, RUN outputs on the 11th.
- `MEM_busy` held 256 cycles with `MEM_TIMEOUT` = 255 → `err` = 1, IDLE; `START` stays ignored until `RST`.
- `EN` low 3 cycles inside FLUSH → remaining count and counters frozen, flush resumes afterwards; `RST` mid-MEM_WAIT → reset values next cycle.
